pulse_video_gen: RTL

Synthesises a 10-bit sampled radar video stream from a programmed pulse descriptor: pulse width, amplitude, repetition interval and count. It is the transmit-side counterpart of the two-threshold pulse descriptor extractor. It drives that extractor's video input in loopback self-test, or the DAC path on the board. It advances only on the sample strobe produced by the clock divider, so its timing matches the extractor's sample grid exactly.

---
 rtl/pulse_video_gen_pkg.sv | 7 +
 rtl/pulse_video_gen_dur_counter.sv | 22 ++
 rtl/pulse_video_gen.sv | 115 +++++++++++
 3 files changed

// File: rtl/pulse_video_gen_pkg.sv
// pulse_video_gen_pkg: shared FSM encoding and default widths for the pulse video generator/extractor pair
package pulse_video_gen_pkg;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_TOA_W = 32;
  localparam int DEF_VID_W = 10;
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
endpackage

// File: rtl/pulse_video_gen_dur_counter.sv
// pulse_dur_counter: loadable down-counter timing PULSE and GAP durations
// Ports: clock, reset_n (async, active-low), load/load_val (load wins), en (decrement), tc (count is zero).
// A state lasting d samples is loaded with d-1 on its first sample; tc marks its last sample.
module pulse_dur_counter
  import pulse_video_gen_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  assign tc = cnt == '0;
endmodule

// File: rtl/pulse_video_gen.sv
// pulse_video_gen: synthesises sampled radar video from a pulse descriptor (pw, pri, count, amp, baseline)
// Ports: clock, reset_n (async, active-low), enable (sample strobe), desc_valid/desc_ready handshake,
//   pw/pri/count/amp/baseline descriptor, abort; outputs video, pulse_active, pulse_idx, toa, done.
module pulse_video_gen
  import pulse_video_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TOA_W = DEF_TOA_W,
  parameter int VID_W = DEF_VID_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  logic [CNT_W-1:0] pw,
  input  logic [CNT_W-1:0] pri,
  input  logic [CNT_W-1:0] count,
  input  logic [VID_W-1:0] amp,
  input  logic [VID_W-1:0] baseline,
  input  logic             abort,
  output logic [VID_W-1:0] video,
  output logic             pulse_active,
  output logic [CNT_W-1:0] pulse_idx,
  output logic [TOA_W-1:0] toa,
  output logic             done
);
  state_t state, state_n;
  logic [CNT_W-1:0] pw_r, pri_r, cnt_r, idx_n, load_val, gap_m1;
  logic [VID_W-1:0] amp_r, base_r, video_n;
  logic [TOA_W-1:0] scnt, toa_n;
  logic pend, pend_n, act_n, done_n, load, tc, accept, degen, more;
  assign desc_ready = state == IDLE;
  assign accept = desc_valid && desc_ready;
  assign degen = pw == '0 || count == '0;
  // pri <= pw still leaves a one-sample gap; subtraction only happens when it cannot underflow
  assign gap_m1 = (pri_r > pw_r) ? pri_r - pw_r - CNT_W'(1) : '0;
  assign more = pulse_idx < cnt_r - CNT_W'(1);
  pulse_dur_counter #(.W(CNT_W)) u_dur (
    .clock(clock), .reset_n(reset_n), .load(load), .load_val(load_val),
    .en(enable && state != IDLE), .tc(tc)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      pend <= 1'b0;
      scnt <= '0;
      video <= '0;
      pulse_active <= 1'b0;
      pulse_idx <= '0;
      toa <= '0;
      done <= 1'b0;
      {pw_r, pri_r, cnt_r, amp_r, base_r} <= '0;
    end else begin
      state <= state_n;
      pend <= pend_n;
      if (enable) scnt <= scnt + TOA_W'(1);
      video <= video_n;
      pulse_active <= act_n;
      pulse_idx <= idx_n;
      toa <= toa_n;
      done <= done_n;
      if (accept) {pw_r, pri_r, cnt_r, amp_r, base_r} <= {pw, pri, count, amp, baseline};
    end
  // A freshly accepted descriptor waits in IDLE (pend) for the next strobe; a new acceptance restarts that wait.
  always_comb begin
    state_n = state;
    pend_n = pend;
    video_n = video;
    act_n = pulse_active;
    idx_n = pulse_idx;
    toa_n = toa;
    done_n = 1'b0;
    load = 1'b0;
    load_val = pw_r - CNT_W'(1);
    if (state == IDLE) begin
      if (accept) begin
        pend_n = !degen;
        done_n = degen;
        video_n = baseline;
      end else if (pend && enable) begin
        state_n = PULSE;
        pend_n = 1'b0;
        video_n = amp_r;
        act_n = 1'b1;
        idx_n = '0;
        toa_n = scnt;
        load = 1'b1;
      end
    end else if (abort) begin
      state_n = IDLE;
      video_n = base_r;
      act_n = 1'b0;
      done_n = 1'b1;
    end else if (enable && tc) begin
      if (state == PULSE) begin
        state_n = GAP;
        video_n = base_r;
        act_n = 1'b0;
        load = 1'b1;
        load_val = gap_m1;
      end else if (more) begin
        state_n = PULSE;
        video_n = amp_r;
        act_n = 1'b1;
        idx_n = pulse_idx + CNT_W'(1);
        toa_n = scnt;
        load = 1'b1;
      end else begin
        state_n = IDLE;
        done_n = 1'b1;
      end
    end
  end
endmodule
